mult_seq: RTL
=============

// Module: mult_seq
// PURPOSE
//  Sequencer for the iterative shift-add multiplier behind the mult/multu ops (aluctrl 4'b0101, fpoint 2'b11).
//  Sits beside the single-cycle control decoder. Stalls PC and register write while it runs, one bit per cycle.
//  Then returns the 2*WIDTH product with a one-cycle done pulse, so the held instruction retires.
// PARAMETERS
//  WIDTH   32  operand width; product is 2*WIDTH; RUN length = WIDTH cycles
//  CNT_W   $clog2(WIDTH)  iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      decoder flags multiply (aluctrl==4'b0101 && fpoint==2'b11)
//  is_signed  in   1      1 = mult (funct 14), 0 = multu (funct 22); sampled with start
//  flush      in   1      synchronous abort (branch/jump redirect)
//  op_a       in   WIDTH  multiplicand (rs1 data), sampled with start
//  op_b       in   WIDTH  multiplier (rs2 data), sampled with start
//  stall      out  1      freeze PC, suppress regwrite/memwrite
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: result valid, instruction retires this cycle
//  result     out  WIDTH  product low word (written to destination register)
//  result_hi  out  WIDTH  product high word
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; counter, accumulator, result, result_hi = 0; stall=busy=done=0.
//  States: IDLE, RUN, FIX, DONE (2-bit encoding).
//  IDLE: start=1 & flush=0 -> latch |op_a|, |op_b| (if is_signed, else raw) and neg=is_signed&(a[W-1]^b[W-1]).
//    Set acc={WIDTH'0, |op_b|}, cnt=0, -> RUN. stall=start&~flush combinationally in IDLE.
//  RUN: if acc[0], acc_hi += mcand with a WIDTH+1-bit carry. Then {carry,acc} >>= 1, cnt++.
//    At cnt==WIDTH-1 -> FIX.
//  FIX: if neg, acc = two's-complement of acc (2*WIDTH bits). Then load result/result_hi. -> DONE.
//  DONE: done=1, stall=0; -> IDLE unconditionally. start is ignored in DONE, so a held start cannot re-trigger.
//  stall = (IDLE&start&~flush) | RUN | FIX. done is high only in DONE.
//  Latency: start sampled in cycle 0; done in cycle WIDTH+2; stall high cycles 0..WIDTH+1 (34 for WIDTH=32).
//  result/result_hi hold their value until the next FIX; they are never cleared by flush.
//  flush: highest priority after reset; any state -> IDLE next edge, no done.
//    A flush that lands in DONE still lets that cycle's done stand (retire already committed).
//  Arithmetic: abs(-2^(W-1)) = 2^(W-1) as an unsigned W-bit value, which is correct.
//    Zero operand gives product 0 whatever neg is.
//  Back-to-back: new start in the IDLE cycle after DONE begins a fresh sequence with no extra bubble.
// STRUCTURE
//  Shared include dlx_defs.vh holds: ALU_MUL=4'b0101, FPNT_MUL=2'b11, FUNCT_MULT=14, FUNCT_MULTU=22,
//    MS_IDLE/MS_RUN/MS_FIX/MS_DONE state codes.
//  mult_seq: FSM, counter, stall/done logic.
//  Sub-module mult_shift_add_dp: operand abs, accumulator add/shift, final negate.
//    Takes control strobes load/step/fix; no state of its own beyond acc/mcand/neg registers.
// TESTING
//  1 multu 7*6: result=42, result_hi=0. done in cycle 34 only. stall high exactly 34 cycles.
//  2 mult -3*5: result=0xFFFFFFF1, result_hi=0xFFFFFFFF.
//    mult 0x80000000*0x80000000: result=0, result_hi=0x40000000.
//  3 multu 0xFFFFFFFF*0xFFFFFFFF: result=0x00000001, result_hi=0xFFFFFFFE.
//    The same operands with mult: result=1, result_hi=0.
//  4 flush in cycle 10 of RUN: IDLE next cycle, stall=0, no done, result unchanged.
//    A following start computes 9*9=81 correctly.
//  5 rst_n low mid-RUN (cycle 5, asynchronous, between edges): all outputs 0 immediately.
//    After release, start 2*3 gives 6.
//  6 start held high through DONE, then two back-to-back multiplies:
//    exactly one done per instruction, the second done in cycle 69.
//    Random signed/unsigned check (>=1000 vectors) against a 64-bit reference model.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg
//   Shared definitions for the iterative multiply sequencer: decoder codes
//   that identify mult/multu and the sequencer state encoding.
package mult_seq_pkg;

  // Decoder values that route an instruction to the multiplier.
  localparam logic [3:0] ALU_MUL     = 4'b0101;
  localparam logic [1:0] FPNT_MUL    = 2'b11;
  localparam logic [5:0] FUNCT_MULT  = 6'd14;
  localparam logic [5:0] FUNCT_MULTU = 6'd22;

  // Sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_FIX  = 2'b10,
    MS_DONE = 2'b11
  } ms_state_e;

endpackage

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp
//   Shift-add datapath for the sequential multiplier. Holds the multiplicand
//   magnitude, the 2*WIDTH accumulator and the sign of the final product.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture operand magnitudes and product sign
//   step         one shift-add iteration
//   fix          apply the sign to the accumulator
//   is_signed    treat operands as two's complement (sampled with load)
//   op_a, op_b   multiplicand / multiplier
//   product      signed-corrected accumulator (valid while fix is asserted)
module mult_shift_add_dp
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 fix,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   product
);

  // Magnitude of an operand; -2^(W-1) maps to 2^(W-1) as an unsigned value.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      abs_val = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_neg_s;

  // Next-state of the accumulator, multiplicand and sign.
  always_comb begin
    acc_neg_s = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
    // Upper half plus multiplicand keeps its carry so nothing is lost on the shift.
    sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    if (load) begin
      mcand_d = abs_val(op_a, is_signed);
      acc_d   = {{WIDTH{1'b0}}, abs_val(op_b, is_signed)};
      neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (step) begin
      acc_d = {sum_s, acc_q[WIDTH-1:1]};
    end else if (fix) begin
      acc_d = neg_q ? acc_neg_s : acc_q;
    end else begin
      acc_d = acc_q;
    end
    product = neg_q ? acc_neg_s : acc_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= {(2*WIDTH){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// mult_seq
//   Sequencer for the iterative mult/multu unit. Stalls the pipeline for
//   WIDTH shift-add cycles plus a sign-fix cycle, then pulses done for one
//   cycle with the 2*WIDTH product on result/result_hi.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, is_signed   launch a multiply (signed when is_signed=1)
//   flush              synchronous abort, returns to IDLE
//   op_a, op_b         operands, sampled with start
//   stall, busy, done  pipeline control / status
//   result, result_hi  product low / high word
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ms_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               load_s, step_s, fix_s;
  logic [2*WIDTH-1:0] product_s;

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .step      (step_s),
    .fix       (fix_s),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .product   (product_s)
  );

  // Next-state, counter, strobes and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    load_s      = 1'b0;
    step_s      = 1'b0;
    fix_s       = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = MS_RUN;
        end else begin
          state_d = MS_IDLE;
        end
      end
      MS_RUN: begin
        step_s = 1'b1;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = MS_FIX;
        end else begin
          state_d = MS_RUN;
        end
      end
      MS_FIX: begin
        fix_s       = 1'b1;
        result_d    = product_s[WIDTH-1:0];
        result_hi_d = product_s[2*WIDTH-1:WIDTH];
        done_d      = 1'b1;
        state_d     = MS_DONE;
      end
      // start is deliberately ignored here so a held start cannot re-trigger.
      MS_DONE: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
    // A redirect kills the sequence wherever it is; results keep their old value.
    if (flush) begin
      state_d     = MS_IDLE;
      done_d      = 1'b0;
      load_s      = 1'b0;
      step_s      = 1'b0;
      fix_s       = 1'b0;
      result_d    = result_q;
      result_hi_d = result_hi_q;
    end else begin
      state_d = state_d;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MS_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      done_q      <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
    end
  end

  // The IDLE term lets the PC freeze in the very cycle the multiply is decoded.
  assign stall     = ((state_q == MS_IDLE) & start & ~flush) |
                     (state_q == MS_RUN) | (state_q == MS_FIX);
  assign busy      = (state_q != MS_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;

endmodule
